// File: rtl/spi_frame_if.sv
// SPI mode-0 slave front end, MSB first, oversampled in the CLK domain.
// One fixed-length frame per CS_N assertion; response word shifted out on MISO.
module spi_frame_if #(
    parameter int unsigned FRAME_W     = 136,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SCLK,
    input  logic               CS_N,
    input  logic               MOSI,
    output logic               MISO,
    output logic               MISO_OE,
    input  logic [FRAME_W-1:0] TO_SEND,
    output logic [FRAME_W-1:0] RECEIVED,
    output logic               FRAME_VALID,
    output logic               FRAME_ERR
);

    localparam int unsigned CW = $clog2(FRAME_W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_W);
    localparam logic [CW-1:0] CNT_OVR  = CW'(FRAME_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_CLOSE
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   armed_q;

    state_e                 state_q;
    logic [FRAME_W-1:0]     rx_q;
    logic [FRAME_W-2:0]     tx_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [FRAME_W-1:0]     received_q;
    logic                   miso_q, miso_oe_q, valid_q, err_q;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    // A frame may only open after CS_N has been seen high with a fully refilled
    // synchroniser, so a CS_N already low when reset releases is not a frame start.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            prime_q     <= '0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            if (prime_q[SYNC_STAGES] && cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != CNT_OVR) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            rx_q       <= '0;
            tx_q       <= '0;
            cnt_q      <= '0;
            received_q <= '0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cs_fall && armed_q) begin
                        state_q   <= S_ACTIVE;
                        tx_q      <= TO_SEND[FRAME_W-2:0];
                        miso_q    <= TO_SEND[FRAME_W-1];
                        miso_oe_q <= 1'b1;
                        // An SCLK rise coincident with the opening edge is bit 0.
                        if (sclk_rise) begin
                            rx_q  <= {rx_q[FRAME_W-2:0], mosi_s};
                            cnt_q <= CW'(1);
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (cs_rise) begin
                        state_q <= S_CLOSE;
                        if (cnt_q == CNT_FULL) begin
                            received_q <= rx_q;
                            valid_q    <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            rx_q  <= {rx_q[FRAME_W-2:0], mosi_s};
                            cnt_q <= cnt_d;
                        end
                        if (sclk_fall) begin
                            miso_q <= tx_q[FRAME_W-2];
                            tx_q   <= {tx_q[FRAME_W-3:0], 1'b0};
                        end
                    end
                end
                S_CLOSE: begin
                    state_q   <= S_IDLE;
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MISO        = miso_q;
    assign MISO_OE     = miso_oe_q;
    assign RECEIVED    = received_q;
    assign FRAME_VALID = valid_q;
    assign FRAME_ERR   = err_q;

endmodule
